// File: rtl/i2c_apb_pkg.sv
// Shared definitions for the I2C APB job sequencer: core register map,
// command/status bit positions, command bytes and the job FSM states.
`timescale 1ns/1ps
package i2c_apb_pkg;

   localparam logic [7:0] A_PRESCALE = 8'h00;
   localparam logic [7:0] A_COMMAND  = 8'h04;
   localparam logic [7:0] A_STATUS   = 8'h08;
   localparam logic [7:0] A_TRANSMIT = 8'h0C;
   localparam logic [7:0] A_RECEIVE  = 8'h10;
   localparam logic [7:0] A_ADDRESS  = 8'h14;

   localparam int POLL_MAX = 255;
   localparam int MAX_LEN  = 8;

   localparam int CMD_B_ENABLE  = 7;
   localparam int CMD_B_TX_PUSH = 6;
   localparam int CMD_B_RX_POP  = 5;
   localparam int CMD_B_CORE_RN = 4;
   localparam int CMD_B_RSTART  = 3;

   localparam int ST_B_TX_FULL  = 7;
   localparam int ST_B_TX_EMPTY = 6;
   localparam int ST_B_RX_FULL  = 5;
   localparam int ST_B_RX_EMPTY = 4;

   localparam logic [7:0] CMD_IDLE = 8'h10;
   localparam logic [7:0] CMD_PUSH = 8'h50;
   localparam logic [7:0] CMD_GO   = 8'h90;
   localparam logic [7:0] CMD_POP  = 8'hB0;
   localparam logic [7:0] CMD_RST  = 8'h00;

   typedef enum logic [3:0] {
      IDLE, PRO_PS, PRO_ADDR, PRO_CMD,
      WAIT_TX, PUSH_DATA, PUSH_SET, PUSH_CLR,
      GO, POLL, POP_SET, POP_CLR,
      RD_RX, STOP, ABORT, DONE
   } seq_state_t;

   function automatic logic len_ok(input logic [3:0] len);
      return (len != 4'd0) && (len <= 4'(MAX_LEN));
   endfunction

endpackage

// File: rtl/apb_master_port.sv
// APB master handshake: one SETUP cycle, then ACCESS held until PREADY.
`timescale 1ns/1ps
module apb_master_port (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_req,
   input  logic [7:0] i_addr,
   input  logic       i_write,
   input  logic [7:0] i_wdata,
   output logic       o_ack,
   output logic [7:0] o_rdata,
   output logic       o_psel,
   output logic       o_penable,
   output logic       o_pwrite,
   output logic [7:0] o_paddr,
   output logic [7:0] o_pwdata,
   input  logic [7:0] i_prdata,
   input  logic       i_pready
);

   logic r_access;

   // SETUP is a combinational function of the request, so a request that is
   // already present in the cycle after an ack starts its SETUP with no gap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_access <= 1'b0;
      end else if (!r_access) begin
         r_access <= i_req;
      end else if (i_pready) begin
         r_access <= 1'b0;
      end
   end

   assign o_psel    = i_req;
   assign o_penable = r_access & i_req;
   assign o_ack     = r_access & i_pready;
   assign o_pwrite  = i_write;
   assign o_paddr   = i_addr;
   assign o_pwdata  = i_wdata;
   assign o_rdata   = i_prdata;

endmodule

// File: rtl/i2c_apb_sequencer.sv
// Runs a full I2C write or read job on the I2C core's APB register file:
// prologue, byte pushes or pops with status polling, stop, and abort on timeout.
`timescale 1ns/1ps
module i2c_apb_sequencer
   import i2c_apb_pkg::*;
(
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       start,
   input  logic       job_rw,
   input  logic [6:0] job_addr,
   input  logic [3:0] job_len,
   input  logic [7:0] job_prescale,
   input  logic [7:0] wr_data,
   input  logic       wr_valid,
   output logic       wr_ready,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       PSELx,
   output logic       PENABLE,
   output logic       PWRITE,
   output logic [7:0] PADDR,
   output logic [7:0] PWDATA,
   input  logic [7:0] PRDATA,
   input  logic       PREADY
);

   seq_state_t r_state, w_state_next;

   logic       r_rw;
   logic [6:0] r_addr;
   logic [7:0] r_prescale;
   logic [3:0] r_cnt;
   logic [7:0] r_poll;
   logic [7:0] r_byte;
   logic       r_err;
   logic [7:0] r_rd_data;
   logic       r_rd_valid;

   logic       w_req;
   logic       w_write;
   logic [7:0] w_addr;
   logic [7:0] w_wdata;
   logic       w_ack;
   logic [7:0] w_rdata;
   logic       w_poll_ok;

   apb_master_port u_apb (
      .i_clk     (PCLK),
      .i_rst_n   (PRESETn),
      .i_req     (w_req),
      .i_addr    (w_addr),
      .i_write   (w_write),
      .i_wdata   (w_wdata),
      .o_ack     (w_ack),
      .o_rdata   (w_rdata),
      .o_psel    (PSELx),
      .o_penable (PENABLE),
      .o_pwrite  (PWRITE),
      .o_paddr   (PADDR),
      .o_pwdata  (PWDATA),
      .i_prdata  (PRDATA),
      .i_pready  (PREADY)
   );

   // Write jobs wait for the TX FIFO to drain; read jobs wait for RX data.
   assign w_poll_ok = r_rw ? ~w_rdata[ST_B_RX_EMPTY] : w_rdata[ST_B_TX_EMPTY];

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state    <= IDLE;
         r_rw       <= 1'b0;
         r_addr     <= 7'd0;
         r_prescale <= 8'd0;
         r_cnt      <= 4'd0;
         r_poll     <= 8'd0;
         r_byte     <= 8'd0;
         r_err      <= 1'b0;
         r_rd_data  <= 8'd0;
         r_rd_valid <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_rd_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_rw       <= job_rw;
                  r_addr     <= job_addr;
                  r_prescale <= job_prescale;
                  r_cnt      <= job_len;
                  r_err      <= ~len_ok(job_len);
               end
            end
            WAIT_TX: begin
               if (wr_valid) begin
                  r_byte <= wr_data;
                  r_cnt  <= r_cnt - 4'd1;
               end
            end
            GO: begin
               if (w_ack) r_poll <= 8'd0;
            end
            POLL: begin
               if (w_ack) r_poll <= r_poll + 8'd1;
            end
            RD_RX: begin
               if (w_ack) begin
                  r_rd_data  <= w_rdata;
                  r_rd_valid <= 1'b1;
                  r_cnt      <= r_cnt - 4'd1;
                  r_poll     <= 8'd0;
               end
            end
            ABORT: begin
               r_err <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_req        = 1'b0;
      w_write      = 1'b1;
      w_addr       = A_COMMAND;
      w_wdata      = 8'h00;
      wr_ready     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_state_next = len_ok(job_len) ? PRO_PS : DONE;
         end
         PRO_PS: begin
            w_req   = 1'b1;
            w_addr  = A_PRESCALE;
            w_wdata = r_prescale;
            if (w_ack) w_state_next = PRO_ADDR;
         end
         PRO_ADDR: begin
            w_req   = 1'b1;
            w_addr  = A_ADDRESS;
            w_wdata = {r_addr, r_rw};
            if (w_ack) w_state_next = PRO_CMD;
         end
         PRO_CMD: begin
            w_req   = 1'b1;
            w_wdata = CMD_IDLE;
            if (w_ack) w_state_next = r_rw ? GO : WAIT_TX;
         end
         WAIT_TX: begin
            // The accepting cycle doubles as the SETUP phase of the TRANSMIT write.
            wr_ready = 1'b1;
            w_req    = wr_valid;
            w_addr   = A_TRANSMIT;
            w_wdata  = wr_data;
            if (wr_valid) w_state_next = PUSH_DATA;
         end
         PUSH_DATA: begin
            w_req   = 1'b1;
            w_addr  = A_TRANSMIT;
            w_wdata = r_byte;
            if (w_ack) w_state_next = PUSH_SET;
         end
         PUSH_SET: begin
            w_req   = 1'b1;
            w_wdata = CMD_PUSH;
            if (w_ack) w_state_next = PUSH_CLR;
         end
         PUSH_CLR: begin
            w_req   = 1'b1;
            w_wdata = CMD_IDLE;
            if (w_ack) w_state_next = (r_cnt == 4'd0) ? GO : WAIT_TX;
         end
         GO: begin
            w_req   = 1'b1;
            w_wdata = CMD_GO;
            if (w_ack) w_state_next = r_rw ? POLL : POLL;
         end
         POLL: begin
            w_req   = 1'b1;
            w_write = 1'b0;
            w_addr  = A_STATUS;
            if (w_ack) begin
               if (w_poll_ok) begin
                  w_state_next = r_rw ? POP_SET : STOP;
               end else if (r_poll == 8'(POLL_MAX - 1)) begin
                  w_state_next = ABORT;
               end
            end
         end
         POP_SET: begin
            w_req   = 1'b1;
            w_wdata = CMD_POP;
            if (w_ack) w_state_next = POP_CLR;
         end
         POP_CLR: begin
            w_req   = 1'b1;
            w_wdata = CMD_GO;
            if (w_ack) w_state_next = RD_RX;
         end
         RD_RX: begin
            w_req   = 1'b1;
            w_write = 1'b0;
            w_addr  = A_RECEIVE;
            if (w_ack) w_state_next = (r_cnt == 4'd1) ? STOP : POLL;
         end
         STOP: begin
            w_req   = 1'b1;
            w_wdata = CMD_IDLE;
            if (w_ack) w_state_next = DONE;
         end
         ABORT: begin
            w_req   = 1'b1;
            w_wdata = CMD_RST;
            if (w_ack) w_state_next = DONE;
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign busy     = (r_state != IDLE);
   assign done     = (r_state == DONE);
   assign err      = (r_state == DONE) & r_err;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;

endmodule
